// File: rtl/rr_stream_sel_if.sv
// Handshake bundle between two producers (x, y), the round-robin selector and its consumer.
// The slave modport is the selector's view; the master modport drives sources and the sink.
interface rr_stream_sel_if #(
  parameter int W = 5
);
  logic         x_valid;
  logic [W-1:0] x_data;
  logic         x_ready;
  logic         y_valid;
  logic [W-1:0] y_data;
  logic         y_ready;
  logic [W-1:0] z;
  logic         z_valid;
  logic         z_ready;
  logic         sel;

  modport slave (
    input  x_valid, x_data, y_valid, y_data, z_ready,
    output x_ready, y_ready, z, z_valid, sel
  );

  modport master (
    output x_valid, x_data, y_valid, y_data, z_ready,
    input  x_ready, y_ready, z, z_valid, sel
  );
endinterface

// File: rtl/rr_stream_sel.sv
// Two-input round-robin stream arbiter with a one-entry output register and bounded bursts.
// sel tags the registered word with its source (0 = x, 1 = y) for the downstream 2:1 selector.
module rr_stream_sel #(
  parameter int W         = 5,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  rr_stream_sel_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_X = 2'd1,
    OWN_Y = 2'd2
  } state_t;

  localparam logic [3:0] MAX_B = 4'(MAX_BURST);

  state_t       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         pri_q, pri_d;     // 0: x wins the next tie, 1: y wins
  logic [W-1:0] z_q, z_d;
  logic         z_valid_q, z_valid_d;
  logic         sel_q, sel_d;

  logic         load_s;
  logic         gnt_x_s;
  logic         gnt_y_s;
  logic [3:0]   cnt_inc_s;

  assign load_s    = !z_valid_q || bus.z_ready;
  assign cnt_inc_s = (cnt_q < MAX_B) ? (cnt_q + 4'd1) : MAX_B;

  // Grant: the owner keeps the slot until its burst budget is spent, then yields to a waiting peer.
  always_comb begin
    gnt_x_s = 1'b0;
    gnt_y_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.x_valid && bus.y_valid) begin
          gnt_x_s = !pri_q;
          gnt_y_s = pri_q;
        end else if (bus.x_valid) begin
          gnt_x_s = 1'b1;
        end else if (bus.y_valid) begin
          gnt_y_s = 1'b1;
        end else begin
          gnt_x_s = 1'b0;
        end
      end
      OWN_X: begin
        if (bus.x_valid && (cnt_q < MAX_B)) begin
          gnt_x_s = 1'b1;
        end else if (bus.y_valid) begin
          gnt_y_s = 1'b1;
        end else if (bus.x_valid) begin
          gnt_x_s = 1'b1;
        end else begin
          gnt_x_s = 1'b0;
        end
      end
      OWN_Y: begin
        if (bus.y_valid && (cnt_q < MAX_B)) begin
          gnt_y_s = 1'b1;
        end else if (bus.x_valid) begin
          gnt_x_s = 1'b1;
        end else if (bus.y_valid) begin
          gnt_y_s = 1'b1;
        end else begin
          gnt_y_s = 1'b0;
        end
      end
      default: begin
        gnt_x_s = 1'b0;
        gnt_y_s = 1'b0;
      end
    endcase
  end

  // Next state: everything holds on a stall; a transfer reloads the slot and updates ownership.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pri_d     = pri_q;
    z_d       = z_q;
    z_valid_d = z_valid_q;
    sel_d     = sel_q;
    if (load_s) begin
      if (gnt_x_s) begin
        z_d       = bus.x_data;
        sel_d     = 1'b0;
        z_valid_d = 1'b1;
        state_d   = OWN_X;
        pri_d     = 1'b1;
        cnt_d     = (state_q == OWN_X) ? cnt_inc_s : 4'd1;
      end else if (gnt_y_s) begin
        z_d       = bus.y_data;
        sel_d     = 1'b1;
        z_valid_d = 1'b1;
        state_d   = OWN_Y;
        pri_d     = 1'b0;
        cnt_d     = (state_q == OWN_Y) ? cnt_inc_s : 4'd1;
      end else begin
        z_valid_d = 1'b0;
        state_d   = IDLE;
        cnt_d     = 4'd0;
      end
    end else begin
      z_valid_d = z_valid_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      pri_q     <= 1'b0;
      z_q       <= '0;
      z_valid_q <= 1'b0;
      sel_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pri_q     <= pri_d;
      z_q       <= z_d;
      z_valid_q <= z_valid_d;
      sel_q     <= sel_d;
    end
  end

  assign bus.x_ready = load_s && gnt_x_s;
  assign bus.y_ready = load_s && gnt_y_s;
  assign bus.z       = z_q;
  assign bus.z_valid = z_valid_q;
  assign bus.sel     = sel_q;

endmodule

// File: tb/tb_rr_stream_sel.sv
// Randomised and directed bench for rr_stream_sel: a cycle reference model plus per-source
// in-order scoreboards checking every drained word against what was accepted.
module tb_rr_stream_sel;
  localparam int W    = 5;
  localparam int MAXB = 4;

  logic clk;
  logic rst_n;

  rr_stream_sel_if #(.W(W)) bus ();

  rr_stream_sel #(.W(W), .MAX_BURST(MAXB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: owner 0 = none, 1 = x, 2 = y; run = length of the current burst.
  int           m_owner;
  int           m_run;
  bit           m_pri_y;
  logic [W-1:0] m_z;
  bit           m_zv;
  bit           m_sel;

  logic [W-1:0] qx[$];
  logic [W-1:0] qy[$];
  int n_acc   = 0;
  int n_drain = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = 0;
    m_run   = 0;
    m_pri_y = 1'b0;
    m_z     = '0;
    m_zv    = 1'b0;
    m_sel   = 1'b0;
    qx.delete();
    qy.delete();
    n_acc   = 0;
    n_drain = 0;
  endtask

  // Which source the rules pick this cycle (0 none, 1 x, 2 y).
  function automatic int pick(input bit xv, input bit yv);
    bit own_v, oth_v;
    int oth;
    if (m_owner == 0) begin
      if (xv && yv) return m_pri_y ? 2 : 1;
      if (xv) return 1;
      if (yv) return 2;
      return 0;
    end
    own_v = (m_owner == 1) ? xv : yv;
    oth_v = (m_owner == 1) ? yv : xv;
    oth   = 3 - m_owner;
    if (own_v && m_run < MAXB) return m_owner;
    if (oth_v) return oth;
    if (own_v) return m_owner;
    return 0;
  endfunction

  // One clock: inputs are already driven; check outputs mid-cycle, advance model, cross the edge.
  task automatic step();
    bit xv, yv, zr, load;
    int g;
    logic [W-1:0] exp_w;
    #1;
    xv = bus.x_valid;
    yv = bus.y_valid;
    zr = bus.z_ready;
    load = !m_zv || zr;
    g = pick(xv, yv);
    check("x_ready", 32'(bus.x_ready), 32'(load && g == 1));
    check("y_ready", 32'(bus.y_ready), 32'(load && g == 2));
    check("z_valid", 32'(bus.z_valid), 32'(m_zv));
    check("z",       32'(bus.z),       32'(m_z));
    check("sel",     32'(bus.sel),     32'(m_sel));
    if (bus.z_valid && zr) begin
      if (bus.sel ? (qy.size() == 0) : (qx.size() == 0)) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        exp_w = bus.sel ? qy.pop_front() : qx.pop_front();
        check("sb_word", 32'(bus.z), 32'(exp_w));
        n_drain++;
      end
    end
    if (load) begin
      if (g != 0) begin
        m_z   = (g == 1) ? bus.x_data : bus.y_data;
        m_sel = (g == 2);
        m_zv  = 1'b1;
        m_run = (m_owner == g) ? ((m_run < MAXB) ? m_run + 1 : MAXB) : 1;
        m_owner = g;
        m_pri_y = (g == 1);
        if (g == 1) qx.push_back(bus.x_data);
        else qy.push_back(bus.y_data);
        n_acc++;
      end else begin
        m_zv    = 1'b0;
        m_owner = 0;
        m_run   = 0;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input bit xv, input logic [W-1:0] xd, input bit yv,
                       input logic [W-1:0] yd, input bit zr);
    bus.x_valid = xv;
    bus.x_data  = xd;
    bus.y_valid = yv;
    bus.y_data  = yd;
    bus.z_ready = zr;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 5'h00, 1'b0, 5'h00, 1'b1);
    model_reset();
    @(negedge clk);
    #1;
    check("rst_z",       32'(bus.z),       32'd0);
    check("rst_z_valid", 32'(bus.z_valid), 32'd0);
    check("rst_sel",     32'(bus.sel),     32'd0);
    check("rst_x_ready", 32'(bus.x_ready), 32'd0);
    check("rst_y_ready", 32'(bus.y_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // First word from x alone
    drive(1'b1, 5'h0A, 1'b0, 5'h00, 1'b1);
    step();
    drive(1'b0, 5'h00, 1'b0, 5'h00, 1'b1);
    #1;
    check("first_z",   32'(bus.z),       32'h0A);
    check("first_zv",  32'(bus.z_valid), 32'd1);
    check("first_sel", 32'(bus.sel),     32'd0);
    step();

    // Both sources valid from a fresh reset: bursts of MAXB alternate starting with x
    do_reset();
    for (int k = 0; k < 16; k++) begin
      drive(1'b1, 5'(8'h01 + k), 1'b1, 5'(8'h11 + k), 1'b1);
      step();
      check("burst_sel", 32'(bus.sel), 32'((k / MAXB) % 2));
    end

    // y alone keeps winning past the burst limit, then x takes over immediately
    for (int k = 0; k < 10; k++) begin
      drive(1'b0, 5'h00, 1'b1, 5'($urandom_range(31)), 1'b1);
      step();
      check("y_only_sel", 32'(bus.sel), 32'd1);
    end
    drive(1'b1, 5'h07, 1'b1, 5'h1E, 1'b1);
    step();
    check("switch_sel", 32'(bus.sel), 32'd0);
    check("switch_z",   32'(bus.z),   32'h07);

    // Load 0x15, then stall three cycles with both valid
    drive(1'b1, 5'h15, 1'b0, 5'h00, 1'b1);
    step();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 5'($urandom_range(31)), 1'b1, 5'($urandom_range(31)), 1'b0);
      step();
      check("stall_z", 32'(bus.z), 32'h15);
    end
    drive(1'b1, 5'h03, 1'b1, 5'h13, 1'b1);
    step();

    // Alternating back-pressure with x only
    for (int k = 0; k < 20; k++) begin
      drive(1'b1, 5'($urandom_range(31)), 1'b0, 5'h00, 1'(k % 2));
      step();
    end

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      drive(1'($urandom_range(3) != 0), 5'($urandom_range(31)),
            1'($urandom_range(3) != 0), 5'($urandom_range(31)),
            1'($urandom_range(3) != 0));
      step();
    end

    // Mid-burst asynchronous reset with a word held
    drive(1'b1, 5'h09, 1'b1, 5'h19, 1'b1);
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_z",       32'(bus.z),       32'd0);
    check("arst_z_valid", 32'(bus.z_valid), 32'd0);
    check("arst_sel",     32'(bus.sel),     32'd0);
    model_reset();
    drive(1'b0, 5'h00, 1'b0, 5'h00, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 5'h0C, 1'b1, 5'h1C, 1'b1);
    step();
    check("tie_after_rst_sel", 32'(bus.sel), 32'd0);
    check("tie_after_rst_z",   32'(bus.z),   32'h0C);

    // Drain and reconcile accepted vs delivered counts
    drive(1'b0, 5'h00, 1'b0, 5'h00, 1'b1);
    step();
    step();
    check("sb_count", 32'(n_acc), 32'(n_drain + (m_zv ? 1 : 0)));
    check("sb_empty", 32'(qx.size() + qy.size()), 32'(m_zv ? 1 : 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
